// File: rtl/exp_golomb_encoding_pkg.sv
// Shared types and widths for the Exp-Golomb bitstream encoder.
// Holds the enc_sel encodings, the FSM state encoding and the buffer geometry.
package exp_golomb_encoding_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = 15;
    localparam int LEN_W  = 4;
    localparam int WORD_W = 16;
    localparam int BUF_W  = 31;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_UE   = 2'b01,
        SEL_SE   = 2'b10,
        SEL_TE   = 2'b11
    } enc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PACK     = 2'd1,
        ST_WAIT_OUT = 2'd2
    } state_e;

endpackage

// File: rtl/exp_golomb_encoding_code_gen.sv
// Combinational Exp-Golomb codeword generator for ue/se values.
// The M leading zeros fall out of zero-extending codeNum+1 to 2M+1 bits.
module exp_golomb_code_gen
    import exp_golomb_encoding_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        sel,
    output logic [CODE_W-1:0] codeword,
    output logic [LEN_W-1:0]  len,
    output logic              err
);

    logic [DATA_W-1:0] code_num;
    logic [DATA_W-1:0] neg_value;
    logic [DATA_W:0]   code_p1;
    logic [3:0]        msb_pos;

    always_comb begin
        neg_value = 8'd0 - value;
        code_num  = value;
        err       = 1'b0;
        case (sel)
            SEL_UE: begin
                code_num = value;
                err      = (value == 8'hFF);
            end
            SEL_SE: begin
                // positive values map to odd codes, zero and negatives to even codes
                if (!value[7] && (value != 8'd0))
                    code_num = {value[6:0], 1'b0} - 8'd1;
                else
                    code_num = {neg_value[6:0], 1'b0};
                err = (value == 8'h80);
            end
            default: begin
                code_num = 8'd0;
                err      = 1'b1;
            end
        endcase

        code_p1 = {1'b0, code_num} + 9'd1;
        msb_pos = 4'd0;
        for (int i = 0; i <= DATA_W; i++) begin
            if (code_p1[i])
                msb_pos = 4'(i);
        end

        len      = {msb_pos[2:0], 1'b1};
        codeword = {{(CODE_W-DATA_W-1){1'b0}}, code_p1};
    end

endmodule

// File: rtl/exp_golomb_encoding.sv
// Exp-Golomb ue/se encoder packing variable-length codes into 16-bit words.
// Pending bits sit right-aligned in a 31-bit buffer so 15 pending + 15 new never overflow.
module exp_golomb_encoding
    import exp_golomb_encoding_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enc_valid,
    output logic                enc_ready,
    input  logic [1:0]          enc_sel,
    input  logic [DATA_W-1:0]   enc_value,
    input  logic                flush_req,
    output logic [WORD_W-1:0]   out_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          bit_cnt,
    output logic                enc_err,
    output logic                flush_done
);

    state_e             state, state_nxt;
    logic [BUF_W-1:0]   pend_buf;
    logic               flush_flag;
    logic [CODE_W-1:0]  code_p0;
    logic [LEN_W-1:0]   len_p0;

    logic [CODE_W-1:0]  gen_code;
    logic [LEN_W-1:0]   gen_len;
    logic               gen_err;

    logic [4:0]         total;
    logic [3:0]         rem_cnt;
    logic [BUF_W-1:0]   merged;
    logic [BUF_W-1:0]   merged_sh;
    logic [BUF_W-1:0]   rem_mask;
    logic [WORD_W-1:0]  flush_word;

    exp_golomb_code_gen u_code_gen (
        .value    (enc_value),
        .sel      (enc_sel),
        .codeword (gen_code),
        .len      (gen_len),
        .err      (gen_err)
    );

    assign total      = {1'b0, bit_cnt} + {1'b0, len_p0};
    assign rem_cnt    = total[3:0];
    assign merged     = (pend_buf << len_p0) | {{(BUF_W-CODE_W){1'b0}}, code_p0};
    assign merged_sh  = merged >> rem_cnt;
    assign rem_mask   = (31'd1 << rem_cnt) - 31'd1;
    assign flush_word = pend_buf[WORD_W-1:0] << (5'd16 - {1'b0, bit_cnt});
    assign enc_ready  = (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enc_valid)
                    state_nxt = gen_err ? ST_IDLE : ST_PACK;
                else if (flush_req && (bit_cnt != 4'd0))
                    state_nxt = ST_WAIT_OUT;
            end
            ST_PACK:     state_nxt = total[4] ? ST_WAIT_OUT : ST_IDLE;
            ST_WAIT_OUT: if (out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: accepted codeword held for the PACK cycle
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && enc_valid && !gen_err) begin
            code_p0 <= gen_code;
            len_p0  <= gen_len;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_buf   <= '0;
            bit_cnt    <= 4'd0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            enc_err    <= 1'b0;
            flush_done <= 1'b0;
            flush_flag <= 1'b0;
        end else begin
            enc_err    <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        enc_err <= gen_err;
                    end else if (flush_req) begin
                        if (bit_cnt != 4'd0) begin
                            out_word   <= flush_word;
                            out_valid  <= 1'b1;
                            flush_flag <= 1'b1;
                        end else begin
                            flush_done <= 1'b1;
                        end
                    end
                end
                ST_PACK: begin
                    if (total[4]) begin
                        out_word  <= merged_sh[WORD_W-1:0];
                        pend_buf  <= merged & rem_mask;
                        out_valid <= 1'b1;
                    end else begin
                        pend_buf  <= merged;
                    end
                    bit_cnt <= rem_cnt;
                end
                ST_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (flush_flag) begin
                            pend_buf   <= '0;
                            bit_cnt    <= 4'd0;
                            flush_flag <= 1'b0;
                            flush_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_golomb_encoding.sv
// Scoreboard bench for exp_golomb_encoding against a bit-queue reference model.
module tb_exp_golomb_encoding;

    logic        clk;
    logic        reset_n;
    logic        enc_valid;
    logic        enc_ready;
    logic [1:0]  enc_sel;
    logic [7:0]  enc_value;
    logic        flush_req;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bit_cnt;
    logic        enc_err;
    logic        flush_done;

    int total = 0;
    int bad   = 0;

    bit          bits[$];
    logic [15:0] exp_q[$];
    int          exp_err = 0;
    int          obs_err = 0;
    int          exp_fd  = 0;
    int          obs_fd  = 0;
    bit          rand_ready = 1'b1;
    bit          done = 1'b0;

    exp_golomb_encoding dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enc_valid  (enc_valid),
        .enc_ready  (enc_ready),
        .enc_sel    (enc_sel),
        .enc_value  (enc_value),
        .flush_req  (flush_req),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_cnt    (bit_cnt),
        .enc_err    (enc_err),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: codeword built from the code-number rules, bits kept in stream order
    task automatic model_encode(input logic [1:0] s, input logic [7:0] v);
        int cn, x, m;
        if (s == 2'b01 && v != 8'hFF) begin
            cn = int'(v);
        end else if (s == 2'b10 && v != 8'h80) begin
            x  = int'($signed(v));
            cn = (x > 0) ? 2 * x - 1 : -2 * x;
        end else begin
            exp_err++;
            return;
        end
        x = cn + 1;
        m = 0;
        while ((x >> (m + 1)) != 0) m++;
        for (int i = 0; i < m; i++) bits.push_back(1'b0);
        for (int i = m; i >= 0; i--) bits.push_back(x[i]);
        if (bits.size() >= 16) begin
            logic [15:0] w;
            for (int i = 0; i < 16; i++) w[15-i] = bits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic model_flush();
        logic [15:0] w;
        if (bits.size() > 0) begin
            for (int i = 0; i < 16; i++) w[15-i] = (i < bits.size()) ? bits[i] : 1'b0;
            bits.delete();
            exp_q.push_back(w);
        end
        exp_fd++;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!enc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = enc_ready;
        if (!ok) check("enc_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] v);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        enc_sel   = s;
        enc_value = v;
        enc_valid = 1'b1;
        model_encode(s, v);
        @(posedge clk);
        #1 enc_valid = 1'b0;
    endtask

    task automatic flush();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        flush_req = 1'b1;
        model_flush();
        @(posedge clk);
        #1 flush_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && enc_ready && !out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_bit_cnt"}, int'(bit_cnt), bits.size());
        check({name, "_enc_err_cnt"}, obs_err, exp_err);
        check({name, "_flush_done_cnt"}, obs_fd, exp_fd);
    endtask

    // out_ready changes away from both edges so the monitor sees a stable value
    initial begin
        out_ready = 1'b0;
        while (!done) begin
            @(posedge clk);
            #2 out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // Monitor: a handshake seen here completes on the following rising edge
    initial begin
        while (!done) begin
            @(negedge clk);
            if (reset_n) begin
                if (enc_err) obs_err++;
                if (flush_done) obs_fd++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_word", int'(out_word), -1);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        check("out_word", int'(out_word), int'(e));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [1:0] s;
        logic [7:0] v;
        int r;

        reset_n   = 1'b0;
        enc_valid = 1'b0;
        enc_sel   = 2'b00;
        enc_value = 8'd0;
        flush_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        check("rst_out_word", int'(out_word), 0);
        check("rst_enc_err", int'(enc_err), 0);
        check("rst_flush_done", int'(flush_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_enc_ready", int'(enc_ready), 1);

        send(2'b01, 8'd3);
        flush();
        drain("ue3_flush");

        for (int i = 0; i < 16; i++) send(2'b01, 8'd0);
        drain("ue0_x16");

        send(2'b01, 8'd254);
        send(2'b01, 8'd0);
        drain("ue254_ue0");

        send(2'b10, 8'd1);
        send(2'b10, 8'hFF);
        send(2'b10, 8'd0);
        flush();
        drain("se_pm0_flush");

        send(2'b11, 8'd5);
        send(2'b10, 8'h80);
        send(2'b00, 8'd1);
        send(2'b01, 8'hFF);
        drain("rejects");

        for (int i = 0; i < 15; i++) send(2'b01, 8'd0);
        send(2'b01, 8'd254);
        drain("cnt15_len15");
        flush();
        flush();
        drain("double_flush");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) v = (s == 2'b01) ? 8'hFF : 8'h80;
            if ($urandom_range(0, 7) == 0) flush();
            send(s, v);
        end
        flush();
        drain("random");

        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) send(2'b01, 8'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out_word", int'(out_word), 16'hFFFF);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_bit_cnt", int'(bit_cnt), 0);
        check("midrst_enc_ready", int'(enc_ready), 1);
        bits.delete();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst_enc_ready", int'(enc_ready), 1);
        rand_ready = 1'b1;
        send(2'b01, 8'd0);
        flush();
        drain("postrst_ue0_flush");

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule
